// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
//   Programmable countdown timer driven by the 1us/1ms/1s tick strobes of the
//   clock divider (or by the raw clock). It counts a loaded number of ticks of
//   the selected unit, then pulses done for one cycle and raises a sticky irq.
//   It runs one-shot or periodic (auto-reload, no dead cycle between periods).
//
//   Optional feature macro: TICK_TIMER_OVERRUN_EN
//     defined   -> extra output 'overrun' (sticky): set when an expiry happens
//                  while irq is still 1, cleared by irq_clr (set wins).
//     undefined -> no overrun port; back-to-back expiries merge into irq.
//
// Ports
//   clk         system clock (tick strobes are in this domain)
//   rst         asynchronous, active-high reset
//   tick_us     1-cycle strobe per microsecond
//   tick_ms     1-cycle strobe per millisecond
//   tick_s      1-cycle strobe per second
//   unit_sel    00=us 01=ms 10=s 11=every clk; sampled on accepted start
//   load_val    tick count; sampled on accepted start
//   periodic    1 = auto-reload; sampled on accepted start
//   start       start request (level), acted on only in IDLE
//   stop        abort request, highest priority
//   irq_clr     clears irq (and overrun)
//   busy        1 while in RUN; this is the registered FSM state, so it also
//               serves as the state observation point
//   done        1-cycle pulse per expiry
//   irq         sticky expiry flag
//   cnt_remain  ticks left in the current period
//
// Handshake: there is no valid/ready pair here. start is a level request that
// is accepted on any clock edge where the FSM is IDLE and stop is low; while
// RUN, start is ignored. stop and irq_clr act on every edge they are high.
// ---------------------------------------------------------------------------
module tick_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_us,
  input  logic                 tick_ms,
  input  logic                 tick_s,
  input  logic [1:0]           unit_sel,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 periodic,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 irq_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 irq,
`ifdef TICK_TIMER_OVERRUN_EN
  output logic                 overrun,
`endif
  output logic [CNT_WIDTH-1:0] cnt_remain
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [1:0]           unit_q;
  logic [CNT_WIDTH-1:0] load_q;
  logic                 periodic_q;
  logic                 sel_tick;
  logic                 expire;

  // Tick selection uses the latched unit, so unit_sel changes during RUN
  // have no effect until the next start.
  always_comb begin
    sel_tick = 1'b0;
    case (unit_q)
      2'b00:   sel_tick = tick_us;
      2'b01:   sel_tick = tick_ms;
      2'b10:   sel_tick = tick_s;
      default: sel_tick = 1'b1;
    endcase
  end

  // An expiry is either a zero-length start (completes immediately without
  // entering RUN) or the last selected tick of a period. stop suppresses both.
  always_comb begin
    expire = 1'b0;
    if (!stop) begin
      if (state == ST_IDLE)
        expire = start && (load_val == '0);
      else
        expire = sel_tick && (cnt_remain == ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      cnt_remain <= '0;
      unit_q     <= 2'b00;
      load_q     <= '0;
      periodic_q <= 1'b0;
    end else begin
      done <= expire;
      // Set wins over a simultaneous clear.
      irq  <= expire | (irq & ~irq_clr);

      if (stop) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        cnt_remain <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              unit_q     <= unit_sel;
              load_q     <= load_val;
              periodic_q <= periodic;
              if (load_val != '0) begin
                state      <= ST_RUN;
                busy       <= 1'b1;
                cnt_remain <= load_val;
              end else begin
                cnt_remain <= '0;
              end
            end
          end
          ST_RUN: begin
            // A tick coinciding with the accepted start never reaches here,
            // since that cycle was spent in IDLE.
            if (sel_tick) begin
              if (cnt_remain == ONE) begin
                if (periodic_q) begin
                  cnt_remain <= load_q;
                end else begin
                  cnt_remain <= '0;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                end
              end else if (cnt_remain != '0) begin
                cnt_remain <= cnt_remain - ONE;
              end
            end
          end
        endcase
      end
    end
  end

`ifdef TICK_TIMER_OVERRUN_EN
  // Uses the pre-update irq: an expiry that finds irq already set means the
  // previous expiry was never serviced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else
      overrun <= (expire & irq) | (overrun & ~irq_clr);
  end
`endif

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_us, tick_ms, tick_s;
  logic [1:0]  unit_sel;
  logic [15:0] load_val;
  logic        periodic, start, stop, irq_clr;
  logic        busy, done, irq;
  logic [15:0] cnt_remain;
`ifdef TICK_TIMER_OVERRUN_EN
  logic        overrun;
`endif

  always #5 clk = ~clk;

  tick_timer #(.CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_us    (tick_us),
    .tick_ms    (tick_ms),
    .tick_s     (tick_s),
    .unit_sel   (unit_sel),
    .load_val   (load_val),
    .periodic   (periodic),
    .start      (start),
    .stop       (stop),
    .irq_clr    (irq_clr),
    .busy       (busy),
    .done       (done),
    .irq        (irq),
`ifdef TICK_TIMER_OVERRUN_EN
    .overrun    (overrun),
`endif
    .cnt_remain (cnt_remain)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    tick_us = 0; tick_ms = 0; tick_s = 0;
    unit_sel = 2'b00; load_val = 16'd0; periodic = 0;
    start = 0; stop = 0; irq_clr = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic eb, input logic ed,
                         input logic ei, input logic [15:0] ec);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".irq"},  {31'd0, irq},  {31'd0, ei});
    chk({tag, ".cnt"},  {16'd0, cnt_remain}, {16'd0, ec});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st, sp, clr;
    logic [1:0]  unit;
    logic [15:0] load;
    logic        per;
    logic [2:0]  tk;   // {s, ms, us}
    logic        e_busy, e_done, e_irq;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sp, input logic clr,
                     input logic [1:0] unit, input logic [15:0] load, input logic per,
                     input logic [2:0] tk, input logic eb, input logic ed,
                     input logic ei, input logic [15:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.clr = clr; v.unit = unit; v.load = load; v.per = per;
    v.tk = tk; v.e_busy = eb; v.e_done = ed; v.e_irq = ei; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Counts selected ticks up since the period began; remaining = load - seen.
  logic        m_run, m_irq, m_done, m_ovr, m_per;
  logic [1:0]  m_unit;
  int          m_load, m_seen;

  function automatic logic unit_tick(input logic [1:0] u);
    if (u == 2'b00) return tick_us;
    if (u == 2'b01) return tick_ms;
    if (u == 2'b10) return tick_s;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_irq = 0; m_done = 0; m_ovr = 0; m_per = 0;
    m_unit = 0; m_load = 0; m_seen = 0;
  endtask

  // Call at the edge, with the inputs that were present for that edge.
  task automatic model_edge();
    logic fired;
    fired = 0;
    if (stop) begin
      m_run = 0; m_seen = 0;
    end else if (!m_run) begin
      if (start) begin
        m_load = int'(load_val); m_unit = unit_sel; m_per = periodic; m_seen = 0;
        if (m_load == 0) fired = 1;
        else m_run = 1;
      end
    end else if (unit_tick(m_unit)) begin
      m_seen = m_seen + 1;
      if (m_seen >= m_load) begin
        fired = 1;
        m_seen = 0;
        if (!m_per) m_run = 0;
      end
    end
    m_ovr  = (fired & m_irq) | (m_ovr & ~irq_clr);
    m_irq  = fired | (m_irq & ~irq_clr);
    m_done = fired;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n_ms;
    int spurious;
    clear_inputs();
    do_reset();

    // Reset state
    chk_out("reset", 0, 0, 0, 16'd0);

    // Table: raw-clock one-shot (load 5), us unit with start-cycle tick,
    // periodic load 4 with held start, config change, stop at cnt 1, re-arm.
    add(1,0,0, 2'b11, 16'd5, 0, 3'b000, 1,0,0, 16'd5);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 1,0,0, 16'd4);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 1,0,0, 16'd3);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 1,0,0, 16'd2);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 1,0,0, 16'd1);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 0,1,1, 16'd0);
    add(0,0,0, 2'b11, 16'd5, 0, 3'b000, 0,0,1, 16'd0);
    add(0,0,1, 2'b11, 16'd5, 0, 3'b000, 0,0,0, 16'd0);
    add(1,0,0, 2'b00, 16'd2, 0, 3'b001, 1,0,0, 16'd2);
    add(0,0,0, 2'b00, 16'd2, 0, 3'b001, 1,0,0, 16'd1);
    add(0,0,0, 2'b00, 16'd2, 0, 3'b110, 1,0,0, 16'd1);
    add(0,0,0, 2'b00, 16'd2, 0, 3'b001, 0,1,1, 16'd0);
    add(1,0,0, 2'b11, 16'd4, 1, 3'b000, 1,0,1, 16'd4);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd3);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd2);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd1);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,1,1, 16'd4);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd3);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd2);
    add(1,0,0, 2'b00, 16'd9, 0, 3'b000, 1,0,1, 16'd1);
    add(1,1,0, 2'b00, 16'd9, 0, 3'b000, 0,0,1, 16'd0);
    add(1,0,0, 2'b11, 16'd9, 0, 3'b000, 1,0,1, 16'd9);
    add(0,1,0, 2'b11, 16'd9, 0, 3'b000, 0,0,1, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stop = vecs[i].sp; irq_clr = vecs[i].clr;
      unit_sel = vecs[i].unit; load_val = vecs[i].load; periodic = vecs[i].per;
      {tick_s, tick_ms, tick_us} = vecs[i].tk;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done,
              vecs[i].e_irq, vecs[i].e_cnt);
    end
    clear_inputs();

    // ms unit, 1000-cycle strobe spacing, us/s noise ignored
    do_reset();
    unit_sel = 2'b01; load_val = 16'd3; start = 1;
    step();
    start = 0;
    chk_out("ms.start", 1, 0, 0, 16'd3);
    n_ms = 0; spurious = 0;
    for (int c = 0; c < 3000; c++) begin
      tick_us = 1'b1;
      tick_s  = (c % 7 == 0);
      tick_ms = (c % 1000 == 999);
      step();
      if (c == 500) chk("ms.hold", {16'd0, cnt_remain}, 32'd3);
      if (tick_ms) begin
        n_ms++;
        chk_out($sformatf("ms.tick%0d", n_ms), n_ms < 3, n_ms == 3, n_ms == 3,
                16'(3 - n_ms));
      end else if (done) begin
        spurious++;
      end
    end
    chk("ms.spurious_done", spurious, 0);
    clear_inputs();

    // load 0: immediate done, never busy; irq_clr colliding with expiry
    do_reset();
    unit_sel = 2'b11; load_val = 16'd0; start = 1;
    step();
    start = 0;
    chk_out("zero.first", 0, 1, 1, 16'd0);
    step();
    chk_out("zero.after", 0, 0, 1, 16'd0);
    irq_clr = 1;
    step();
    chk("zero.clr", {31'd0, irq}, 32'd0);
    start = 1;
    step();
    start = 0; irq_clr = 0;
    chk_out("zero.setwins", 0, 1, 1, 16'd0);
    step();
    chk_out("zero.idle", 0, 0, 1, 16'd0);

    // Async reset mid-RUN, start held through release re-arms
    do_reset();
    unit_sel = 2'b11; load_val = 16'd0; start = 1;
    step();
    load_val = 16'd10;
    step();
    chk_out("rst.run", 1, 0, 1, 16'd10);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk_out("rst.async", 0, 0, 0, 16'd0);
    load_val = 16'd2;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 0;
    chk_out("rst.rearm", 1, 0, 0, 16'd2);
    step();
    step();
    chk_out("rst.done", 0, 1, 1, 16'd0);
    clear_inputs();

`ifdef TICK_TIMER_OVERRUN_EN
    do_reset();
    unit_sel = 2'b11; load_val = 16'd2; periodic = 1; start = 1;
    step();
    start = 0;
    step();
    step();
    chk("ovr.first", {31'd0, overrun}, 32'd0);
    chk("ovr.irq1", {31'd0, irq}, 32'd1);
    step();
    step();
    chk("ovr.second", {31'd0, overrun}, 32'd1);
    irq_clr = 1; stop = 1;
    step();
    chk("ovr.clr", {31'd0, overrun}, 32'd0);
    chk("ovr.irqclr", {31'd0, irq}, 32'd0);
    clear_inputs();
`endif

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      irq_clr  = ($urandom_range(0, 19) == 0);
      unit_sel = 2'($urandom_range(0, 3));
      load_val = 16'($urandom_range(0, 6));
      periodic = 1'($urandom_range(0, 1));
      tick_us  = 1'($urandom_range(0, 1));
      tick_ms  = ($urandom_range(0, 3) == 0);
      tick_s   = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      model_edge();
      #1;
      chk_out($sformatf("rnd%0d", c), m_run, m_done, m_irq,
              m_run ? 16'(m_load - m_seen) : 16'd0);
`ifdef TICK_TIMER_OVERRUN_EN
      chk($sformatf("rnd%0d.ovr", c), {31'd0, overrun}, {31'd0, m_ovr});
`endif
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
